// File: rtl/uart_core.sv
// Full-duplex UART with independent TX and RX engines, valid/ready byte handshakes and RX error flags.
// Optional UART_LOOPBACK_EN adds a loopback input that routes TX into RX and holds the Tx pin high.
module uart_core #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 Tx,
   input  logic                 Rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
`ifdef UART_LOOPBACK_EN
   input  logic                 loopback,
`endif
   output logic                 rx_overrun
);
   localparam int BIT_CLKS    = CLK_FREQ / BAUD_RATE;
   localparam int SAMPLE_CLKS = BIT_CLKS / OVERSAMPLE;
   localparam int CW = $clog2(BIT_CLKS + 1);
   localparam int SW = $clog2(SAMPLE_CLKS + 1);
   localparam int TW = $clog2(OVERSAMPLE + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
   localparam logic [SW-1:0] SMP_LAST  = SW'(SAMPLE_CLKS - 1);
   localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic          PAR_EN    = (PARITY != 0);
   localparam logic          PAR_ODD   = (PARITY == 1);

   localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2,
                          S_PAR  = 3'd3, S_STOP  = 3'd4, S_WAIT = 3'd5;

   // ---------------- TX ----------------
   logic [2:0]           tx_st_q, tx_st_d;
   logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
   logic [3:0]           tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
   logic                 tx_par_q, tx_par_d, tx_line_q, tx_line_d;
   logic                 tx_bit_end, tx_accept;

   assign tx_bit_end = (tx_cnt_q == BIT_LAST);
   // Ready rises on the final stop clock so a queued byte follows with no idle gap.
   assign tx_ready   = (tx_st_q == S_IDLE) ||
                       (tx_st_q == S_STOP && tx_bit_end && tx_bit_q == STOP_LAST);
   assign tx_accept  = tx_valid && tx_ready;

   always_comb begin
      tx_st_d   = tx_st_q;
      tx_cnt_d  = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
      tx_bit_d  = tx_bit_q;
      tx_sh_d   = tx_sh_q;
      tx_par_d  = tx_par_q;
      tx_line_d = tx_line_q;
      case (tx_st_q)
         S_START: if (tx_bit_end) begin
            tx_st_d   = S_DATA;
            tx_line_d = tx_sh_q[0];
            tx_sh_d   = tx_sh_q >> 1;
            tx_bit_d  = '0;
         end
         S_DATA: if (tx_bit_end) begin
            if (tx_bit_q == DATA_LAST) begin
               tx_st_d   = PAR_EN ? S_PAR : S_STOP;
               tx_line_d = PAR_EN ? tx_par_q : 1'b1;
               tx_bit_d  = '0;
            end else begin
               tx_line_d = tx_sh_q[0];
               tx_sh_d   = tx_sh_q >> 1;
               tx_bit_d  = tx_bit_q + 4'd1;
            end
         end
         S_PAR: if (tx_bit_end) begin
            tx_st_d   = S_STOP;
            tx_line_d = 1'b1;
            tx_bit_d  = '0;
         end
         S_STOP: if (tx_bit_end) begin
            if (tx_bit_q == STOP_LAST) tx_st_d = S_IDLE;
            else                       tx_bit_d = tx_bit_q + 4'd1;
         end
         default: ;
      endcase
      if (tx_accept) begin
         tx_st_d   = S_START;
         tx_cnt_d  = '0;
         tx_sh_d   = tx_data;
         tx_par_d  = (^tx_data) ^ PAR_ODD;
         tx_line_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_st_q <= S_IDLE; tx_cnt_q <= '0; tx_bit_q <= '0;
         tx_sh_q <= '0; tx_par_q <= 1'b0; tx_line_q <= 1'b1;
      end else begin
         tx_st_q <= tx_st_d; tx_cnt_q <= tx_cnt_d; tx_bit_q <= tx_bit_d;
         tx_sh_q <= tx_sh_d; tx_par_q <= tx_par_d; tx_line_q <= tx_line_d;
      end
   end

   // ---------------- RX ----------------
   logic rx_line, rx_meta_q, rx_sync_q, rx_tick;

`ifdef UART_LOOPBACK_EN
   assign rx_line = loopback ? tx_line_q : Rx;
   assign Tx      = loopback ? 1'b1 : tx_line_q;
`else
   assign rx_line = Rx;
   assign Tx      = tx_line_q;
`endif

   logic [2:0]           rx_st_q, rx_st_d;
   logic [SW-1:0]        rx_scnt_q, rx_scnt_d;
   logic [TW-1:0]        rx_tcnt_q, rx_tcnt_d;
   logic [3:0]           rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
   logic rx_pbit_q, rx_pbit_d, rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
   logic rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, rx_hs;

   assign rx_tick = (rx_scnt_q == SMP_LAST);
   assign rx_hs   = rx_valid_q && rx_ready;

   always_comb begin
      rx_st_d    = rx_st_q;
      rx_scnt_d  = rx_tick ? '0 : rx_scnt_q + 1'b1;
      rx_tcnt_d  = rx_tcnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_pbit_d  = rx_pbit_q;
      rx_data_d  = rx_data_q;
      rx_perr_d  = rx_perr_q;
      rx_ferr_d  = rx_ferr_q;
      rx_valid_d = rx_hs ? 1'b0 : rx_valid_q;
      rx_ovr_d   = rx_hs ? 1'b0 : rx_ovr_q;
      case (rx_st_q)
         S_IDLE: if (!rx_sync_q) begin
            rx_st_d   = S_START;
            rx_tcnt_d = '0;
            rx_scnt_d = '0;
         end
         S_START: if (rx_tick) begin
            if (rx_tcnt_q == TICK_HALF) begin
               rx_tcnt_d = '0;
               rx_bit_d  = '0;
               rx_st_d   = rx_sync_q ? S_IDLE : S_DATA;
            end else rx_tcnt_d = rx_tcnt_q + 1'b1;
         end
         S_DATA, S_PAR, S_STOP: if (rx_tick) begin
            if (rx_tcnt_q != TICK_LAST) rx_tcnt_d = rx_tcnt_q + 1'b1;
            else begin
               rx_tcnt_d = '0;
               if (rx_st_q == S_DATA) begin
                  rx_sh_d = {rx_sync_q, rx_sh_q[DATA_BITS-1:1]};
                  rx_bit_d = rx_bit_q + 4'd1;
                  if (rx_bit_q == DATA_LAST) rx_st_d = PAR_EN ? S_PAR : S_STOP;
               end else if (rx_st_q == S_PAR) begin
                  rx_pbit_d = rx_sync_q;
                  rx_st_d   = S_STOP;
               end else begin
                  // A pending unread word is overwritten; a same-clock handshake is not an overrun.
                  rx_data_d  = rx_sh_q;
                  rx_perr_d  = PAR_EN & ((^rx_sh_q) ^ rx_pbit_q ^ PAR_ODD);
                  rx_ferr_d  = ~rx_sync_q;
                  rx_valid_d = 1'b1;
                  if (rx_valid_q && !rx_ready) rx_ovr_d = 1'b1;
                  rx_st_d    = rx_sync_q ? S_IDLE : S_WAIT;
               end
            end
         end
         S_WAIT: if (rx_sync_q) rx_st_d = S_IDLE;
         default: rx_st_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1; rx_sync_q <= 1'b1;
         rx_st_q <= S_IDLE; rx_scnt_q <= '0; rx_tcnt_q <= '0; rx_bit_q <= '0;
         rx_sh_q <= '0; rx_pbit_q <= 1'b0; rx_data_q <= '0;
         rx_perr_q <= 1'b0; rx_ferr_q <= 1'b0; rx_valid_q <= 1'b0; rx_ovr_q <= 1'b0;
      end else begin
         rx_meta_q <= rx_line; rx_sync_q <= rx_meta_q;
         rx_st_q <= rx_st_d; rx_scnt_q <= rx_scnt_d; rx_tcnt_q <= rx_tcnt_d; rx_bit_q <= rx_bit_d;
         rx_sh_q <= rx_sh_d; rx_pbit_q <= rx_pbit_d; rx_data_q <= rx_data_d;
         rx_perr_q <= rx_perr_d; rx_ferr_q <= rx_ferr_d; rx_valid_q <= rx_valid_d; rx_ovr_q <= rx_ovr_d;
      end
   end

   assign rx_data       = rx_data_q;
   assign rx_valid      = rx_valid_q;
   assign rx_parity_err = rx_perr_q;
   assign rx_frame_err  = rx_ferr_q;
   assign rx_overrun    = rx_ovr_q;
endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: instance 0 is 8N1, instance 1 is 8E1, both at 16 clocks per bit.
module tb_uart_core;
   localparam int BC = 16;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0][7:0] tx_data, rx_data;
   logic [1:0] tx_valid, tx_ready, Tx, Rx, rx_valid, rx_ready, rx_perr, rx_ferr, rx_ovr;
   logic [1:0] rx_auto, tx_mon_en;
`ifdef UART_LOOPBACK_EN
   logic [1:0] lpbk;
`endif

   int errors = 0, checks = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed { logic [7:0] d; logic pe; logic fe; } rx_exp_t;
   logic [7:0] txq [2][$];
   rx_exp_t    rxq [2][$];

   uart_core #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .PARITY(0)) u_n (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
      .Tx(Tx[0]), .Rx(Rx[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
      .rx_parity_err(rx_perr[0]), .rx_frame_err(rx_ferr[0]),
`ifdef UART_LOOPBACK_EN
      .loopback(lpbk[0]),
`endif
      .rx_overrun(rx_ovr[0]));

   uart_core #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .PARITY(2)) u_e (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
      .Tx(Tx[1]), .Rx(Rx[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
      .rx_parity_err(rx_perr[1]), .rx_frame_err(rx_ferr[1]),
`ifdef UART_LOOPBACK_EN
      .loopback(lpbk[1]),
`endif
      .rx_overrun(rx_ovr[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: line level of each bit slot of a frame.
   function automatic int par_of(input int i);
      return (i == 0) ? 0 : 2;
   endfunction

   function automatic logic par_bit(input logic [7:0] d, input int par);
      int ones;
      ones = $countones(d);
      return (par == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
   endfunction

   function automatic int frame(input logic [7:0] d, input int par, input bit flip,
                                output logic [15:0] b);
      int n;
      b = '1;
      b[0] = 1'b0;
      for (int k = 0; k < 8; k++) b[1+k] = d[k];
      n = 9;
      if (par != 0) begin
         b[9] = par_bit(d, par) ^ flip;
         n = 10;
      end
      return n + 1;
   endfunction

   task automatic tx_mon(input int i);
      logic [15:0] b;
      logic [7:0]  d;
      int n, bad;
      forever begin
         @(negedge clk);
         if (tx_mon_en[i] && Tx[i] === 1'b0) begin
            if (txq[i].size() == 0) begin
               chk($sformatf("tx_unexpected[%0d]", i), 1, 0);
               repeat (200) @(negedge clk);
            end else begin
               d = txq[i].pop_front();
               n = frame(d, par_of(i), 1'b0, b);
               bad = 0;
               for (int k = 0; k < n * BC; k++) begin
                  if (k > 0) @(negedge clk);
                  if (Tx[i] !== b[k/BC]) bad++;
               end
               chk($sformatf("tx_wave[%0d] byte %0h bad clocks", i, d), bad, 0);
            end
         end
      end
   endtask

   task automatic rx_mon(input int i);
      rx_exp_t e;
      forever begin
         @(negedge clk);
         if (rx_auto[i] && rx_valid[i]) begin
            if (rxq[i].size() == 0) chk($sformatf("rx_unexpected[%0d]", i), 1, 0);
            else begin
               e = rxq[i].pop_front();
               chk($sformatf("rx_data[%0d]", i), rx_data[i], e.d);
               chk($sformatf("rx_perr[%0d]", i), rx_perr[i], e.pe);
               chk($sformatf("rx_ferr[%0d]", i), rx_ferr[i], e.fe);
               chk($sformatf("rx_ovr[%0d]", i), rx_ovr[i], 0);
            end
            rx_ready[i] = 1'b1;
            @(posedge clk); #1;
            rx_ready[i] = 1'b0;
         end
      end
   endtask

   initial tx_mon(0);
   initial tx_mon(1);
   initial rx_mon(0);
   initial rx_mon(1);

   // Called and returns at posedge+1.
   task automatic tx_send(input int i, input logic [7:0] d, input bit push, output int acc_cyc);
      bit ok;
      ok = 1'b0;
      tx_data[i] = d;
      tx_valid[i] = 1'b1;
      if (push) txq[i].push_back(d);
      for (int c = 0; c < 4000 && !ok; c++) begin
         ok = tx_ready[i];
         @(posedge clk); #1;
      end
      tx_valid[i] = 1'b0;
      acc_cyc = cyc;
      if (!ok) chk($sformatf("tx_accept_timeout[%0d]", i), 0, 1);
   endtask

   task automatic rx_frame(input int i, input logic [7:0] d, input bit flip, input int stop_low,
                           input bit push);
      logic [15:0] b;
      rx_exp_t e;
      int n;
      n = frame(d, par_of(i), flip, b);
      e.d = d;
      e.pe = flip && (par_of(i) != 0);
      e.fe = (stop_low > 0);
      if (push) rxq[i].push_back(e);
      for (int k = 0; k < n - 1; k++) begin
         Rx[i] = b[k];
         repeat (BC) @(posedge clk); #1;
      end
      if (stop_low > 0) begin
         Rx[i] = 1'b0;
         repeat (stop_low) @(posedge clk); #1;
      end
      Rx[i] = 1'b1;
      repeat (BC) @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk); #1;
   endtask

   initial begin
      int c1, c2, n;
      tx_data = '0; tx_valid = '0; Rx = '1; rx_ready = '0;
      rx_auto = '1; tx_mon_en = '1;
`ifdef UART_LOOPBACK_EN
      lpbk = '0;
`endif
      idle(3);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_Tx[%0d]", i), Tx[i], 1);
         chk($sformatf("rst_tx_ready[%0d]", i), tx_ready[i], 1);
         chk($sformatf("rst_rx_valid[%0d]", i), rx_valid[i], 0);
         chk($sformatf("rst_rx_data[%0d]", i), rx_data[i], 0);
         chk($sformatf("rst_errs[%0d]", i), {rx_perr[i], rx_ferr[i], rx_ovr[i]}, 0);
      end
      rst_n = 1'b1;
      idle(2);

      // 8N1 0xA5: waveform by monitor, ready low for all but the last stop clock.
      tx_send(0, 8'hA5, 1'b1, c1);
      n = 0;
      while (!tx_ready[0] && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("tx_ready_low_clks", n, 10 * BC - 1);
      idle(20);

      // Back-to-back frames: accept spacing equals one frame length.
      for (int i = 0; i < 2; i++) begin
         tx_send(i, 8'h3C, 1'b1, c1);
         tx_send(i, 8'hC3, 1'b1, c2);
         chk($sformatf("b2b_spacing[%0d]", i), c2 - c1, (i == 0) ? 10 * BC : 11 * BC);
         idle(12 * BC);
      end

      // Even parity: good then flipped parity bit.
      rx_frame(1, 8'h3C, 1'b0, 0, 1'b1);
      idle(20);
      rx_frame(1, 8'h3C, 1'b1, 0, 1'b1);
      idle(20);

      // Stop held low: frame error, nothing more until the line returns high.
      rx_frame(0, 8'h96, 1'b0, 40, 1'b1);
      idle(40);

      // Short low glitch yields no word.
      Rx[0] = 1'b0;
      idle(4);
      Rx[0] = 1'b1;
      idle(100);
      chk("glitch_no_valid", rx_valid[0], 0);

      // Randomized full-duplex traffic.
      for (int i = 0; i < 2; i++) begin
         fork
            begin
               int ca;
               for (int r = 0; r < 5; r++) begin
                  tx_send(i, 8'($urandom), 1'b1, ca);
                  idle($urandom_range(0, 30));
               end
            end
            begin
               for (int r = 0; r < 5; r++) begin
                  rx_frame(i, 8'($urandom), 1'($urandom_range(0, 1)), 0, 1'b1);
                  idle($urandom_range(0, 25));
               end
            end
         join
         idle(12 * BC);
      end

      // Overrun: two unread frames, then one handshake clears valid and overrun.
      rx_auto[0] = 1'b0;
      rx_frame(0, 8'h11, 1'b0, 0, 1'b0);
      rx_frame(0, 8'h22, 1'b0, 0, 1'b0);
      idle(5);
      chk("ovr_valid", rx_valid[0], 1);
      chk("ovr_data", rx_data[0], 8'h22);
      chk("ovr_flag", rx_ovr[0], 1);
      rx_ready[0] = 1'b1;
      idle(1);
      rx_ready[0] = 1'b0;
      chk("ovr_clr_valid", rx_valid[0], 0);
      chk("ovr_clr_flag", rx_ovr[0], 0);
      rx_auto[0] = 1'b1;
      idle(20);

`ifdef UART_LOOPBACK_EN
      begin
         int lows;
         rx_exp_t e;
         tx_mon_en[0] = 1'b0;
         lpbk[0] = 1'b1;
         e.d = 8'h5A; e.pe = 1'b0; e.fe = 1'b0;
         rxq[0].push_back(e);
         tx_send(0, 8'h5A, 1'b0, c1);
         lows = 0;
         for (int k = 0; k < 12 * BC; k++) begin
            @(negedge clk);
            if (Tx[0] !== 1'b1) lows++;
         end
         chk("loopback_Tx_high", lows, 0);
         idle(20);
         lpbk[0] = 1'b0;
         tx_mon_en[0] = 1'b1;
      end
`endif

      n = 0;
      while ((txq[0].size() + txq[1].size() + rxq[0].size() + rxq[1].size()) != 0 && n < 3000) begin
         idle(1);
         n++;
      end
      chk("txq_drained", txq[0].size() + txq[1].size(), 0);
      chk("rxq_drained", rxq[0].size() + rxq[1].size(), 0);

      // Reset in the middle of a frame returns the line and ready immediately.
      tx_mon_en[0] = 1'b0;
      tx_send(0, 8'h00, 1'b0, c1);
      idle(50);
      chk("midtx_line_low", Tx[0], 0);
      rst_n = 1'b0;
      #1;
      chk("midtx_rst_Tx", Tx[0], 1);
      chk("midtx_rst_ready", tx_ready[0], 1);
      idle(2);
      rst_n = 1'b1;
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
